// File: rtl/spi_reg_ctrl.sv
// SPI register controller: turns an SPI slave byte stream into
// register write bursts and read bursts with auto-increment.
module spi_reg_ctrl #(
  parameter logic [7:0] IDLE_BYTE = 8'hA5
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_SPI_CS_n,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  output logic [6:0] o_Reg_Addr,
  output logic       o_Reg_Wr_En,
  output logic [7:0] o_Reg_Wr_Data,
  output logic       o_Reg_Rd_En,
  input  logic [7:0] i_Reg_Rd_Data,
  output logic       o_Busy,
  output logic       o_Overrun
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_REQ,
    RD_CAP,
    RD
  } state_t;

  state_t state;
  logic   cs_meta;
  logic   cs_sync;
  logic   leave;
  logic   rd_busy;

  assign leave   = cs_sync && (state != IDLE);
  assign rd_busy = (state == RD_REQ) || (state == RD_CAP);

  // two-flop synchroniser for the asynchronous chip select
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
    end else begin
      cs_meta <= i_SPI_CS_n;
      cs_sync <= cs_meta;
    end
  end

  // transaction sequencer; every strobe is a registered pulse
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= IDLE;
      o_TX_DV       <= 1'b0;
      o_TX_Byte     <= IDLE_BYTE;
      o_Reg_Addr    <= 7'd0;
      o_Reg_Wr_En   <= 1'b0;
      o_Reg_Wr_Data <= 8'd0;
      o_Reg_Rd_En   <= 1'b0;
      o_Busy        <= 1'b0;
      o_Overrun     <= 1'b0;
    end else begin
      o_TX_DV     <= 1'b0;
      o_Reg_Wr_En <= 1'b0;
      o_Reg_Rd_En <= 1'b0;

      // a write strobe just issued: step to the next register
      if (o_Reg_Wr_En) begin
        o_Reg_Addr <= o_Reg_Addr + 7'd1;
      end

      // data bytes in a write burst are committed even on CS rise
      if (state == WR && i_RX_DV) begin
        o_Reg_Wr_En   <= 1'b1;
        o_Reg_Wr_Data <= i_RX_Byte;
      end

      // a byte arriving while a fetch is in flight is lost
      if (rd_busy && i_RX_DV) begin
        o_Overrun <= 1'b1;
      end

      if (leave) begin
        state     <= IDLE;
        o_Busy    <= 1'b0;
        o_TX_DV   <= 1'b1;
        o_TX_Byte <= IDLE_BYTE;
      end else begin
        unique case (state)
          IDLE: begin
            if (!cs_sync) begin
              state  <= CMD;
              o_Busy <= 1'b1;
            end
          end
          CMD: begin
            if (i_RX_DV) begin
              o_Reg_Addr <= i_RX_Byte[6:0];
              if (i_RX_Byte[7]) begin
                state <= WR;
              end else begin
                state       <= RD_REQ;
                o_Reg_Rd_En <= 1'b1;
              end
            end
          end
          WR: begin
            state <= WR;
          end
          RD_REQ: begin
            state <= RD_CAP;
          end
          RD_CAP: begin
            o_TX_Byte  <= i_Reg_Rd_Data;
            o_TX_DV    <= 1'b1;
            o_Reg_Addr <= o_Reg_Addr + 7'd1;
            state      <= RD;
          end
          RD: begin
            if (i_RX_DV) begin
              state       <= RD_REQ;
              o_Reg_Rd_En <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter IDLE_BYTE, default 8'hA5, byte loaded for MISO outside read bursts.
REQ-002 SHALL have port i_Clk  input  1  system clock; the block uses one clock only.
REQ-003 SHALL have port i_Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_SPI_CS_n  input  1  SPI chip select, asynchronous, active low.
REQ-005 SHALL have port i_RX_DV  input  1  one-cycle pulse, received byte valid.
REQ-006 SHALL have port i_RX_Byte  input  8  received byte, valid with i_RX_DV.
REQ-007 SHALL have port o_TX_DV  output  1  one-cycle pulse, load o_TX_Byte into the SPI peripheral.
REQ-008 SHALL have port o_TX_Byte  output  8  next byte to serialise on MISO.
REQ-009 SHALL have port o_Reg_Addr  output  7  register address.
REQ-010 SHALL have port o_Reg_Wr_En  output  1  one-cycle write strobe.
REQ-011 SHALL have port o_Reg_Wr_Data  output  8  write data, valid with o_Reg_Wr_En.
REQ-012 SHALL have port o_Reg_Rd_En  output  1  one-cycle read strobe.
REQ-013 SHALL have port i_Reg_Rd_Data  input  8  read data, valid exactly 1 cycle after o_Reg_Rd_En.
REQ-014 SHALL have port o_Busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port o_Overrun  output  1  sticky error flag.

Function
REQ-016 SHALL synchronise i_SPI_CS_n through 2 flops (reset value 1); cs_sync denotes the second flop.
REQ-017 SHALL implement states IDLE, CMD, WR, RD_REQ, RD_CAP and RD.
REQ-018 SHALL move IDLE->CMD when cs_sync==0; all other IDLE inputs are ignored, including i_RX_DV.
REQ-019 SHALL decode the command byte on i_RX_DV in CMD: bit7=1 is a write and goes to WR; bit7=0 is a read and goes to RD_REQ; in both cases o_Reg_Addr<=bits[6:0].
REQ-020 In WR, on each i_RX_DV, SHALL pulse o_Reg_Wr_En with o_Reg_Wr_Data=i_RX_Byte at the current address in the next cycle, then increment the address.
REQ-021 In RD_REQ, SHALL pulse o_Reg_Rd_En for 1 cycle, then go to RD_CAP.
REQ-022 In RD_CAP, SHALL latch o_TX_Byte=i_Reg_Rd_Data, pulse o_TX_DV, increment the address and go to RD.
REQ-023 In RD, on i_RX_DV (dummy byte), SHALL go to RD_REQ, so burst reads continue at the incremented address.
REQ-024 SHALL assert o_TX_DV exactly 3 cycles after the i_RX_DV that triggered the fetch (CMD or RD).
REQ-025 SHALL wrap the address modulo 128: 7'h7F+1=7'h00.
REQ-026 SHALL return to IDLE from any non-IDLE state when cs_sync==1, pulsing o_TX_DV with o_TX_Byte=IDLE_BYTE on that transition.
REQ-027 On simultaneous i_RX_DV and cs_sync rise in WR, SHALL still perform the write and then go to IDLE.
REQ-028 On simultaneous i_RX_DV and cs_sync rise in CMD, RD or RD_REQ/RD_CAP, SHALL go to IDLE with no register access.
REQ-029 SHALL set o_Overrun on i_RX_DV while in RD_REQ or RD_CAP; the byte is dropped, the fetch continues, and only reset clears the flag.
REQ-030 SHALL never assert o_Reg_Wr_En and o_Reg_Rd_En in the same cycle.

Reset
REQ-031 On i_Rst, SHALL set state=IDLE, both CS sync flops=1, o_TX_DV=0, o_TX_Byte=IDLE_BYTE, o_Reg_Addr=0, o_Reg_Wr_En=0, o_Reg_Wr_Data=0, o_Reg_Rd_En=0, o_Busy=0 and o_Overrun=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no strobes on the following cycle, and SHALL require cs_sync to be seen 0 again after reset before leaving IDLE.

Verification
REQ-033 Write burst: CS low, bytes 8'h85, 8'h11, 8'h22, then CS high -> Wr_En at addr 5 data 8'h11 and addr 6 data 8'h22; one TX_DV with 8'hA5 at the end.
REQ-034 Read burst: regs 7'h10=8'h3C and 7'h11=8'h4D, bytes 8'h10, 8'h00 -> TX_DV 8'h3C 3 cycles after the first RX_DV, and 8'h4D 3 cycles after the second.
REQ-035 Wrap: write command 8'hFF, data 8'hAA, 8'hBB -> writes at addr 7F and then addr 00.
REQ-036 Overrun: RX_DV 1 cycle after the read command -> o_Overrun=1 held, TX_DV still issued with the fetched data.
REQ-037 CS high coincident with the final write RX_DV -> write performed, state IDLE, o_Busy=0 the cycle after.
REQ-038 i_Rst pulsed in WR -> outputs at reset values, no Wr_En; a later RX_DV with CS still high is ignored.
